// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode encodings, memory-stage FSM states and SC result values.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    BEQ   = 6'b000100,
    ADDI  = 6'b001000,
    LW    = 6'b100011,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000,
    HALT  = 6'b111111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    HALTED
  } mem_state_t;

  localparam logic [31:0] SC_PASS = 32'd1;
  localparam logic [31:0] SC_FAIL = 32'd0;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == LW) || (op == SW) || (op == LL) || (op == SC);
  endfunction

endpackage

// File: rtl/mem_access_unit_llsc_link_reg.sv
// LL/SC link register: set on LL completion, cleared by SC or by a store to the linked address.
module llsc_link_reg #(
  parameter int ADDR_W  = 32,
  parameter bit LLSC_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              link_valid,
  output logic              link_match
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (set_en) begin
      valid_d = 1'b1;
      addr_d  = set_addr;
    end
    // clear wins over a simultaneous set
    if (clr_en || !LLSC_EN) valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign link_valid = valid_q;
  assign link_match = valid_q && (addr_q == cmp_addr);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: drives dmem requests, stalls upstream while outstanding,
// returns load/SC results with a one-cycle completion strobe and a sticky halt.
//
//   state  | meaning
//   IDLE   | no request; accepts a memory op or a halt from EX/MEM
//   REQ    | dmem request held stable until dhit; pipeline stalled
//   DONE   | mem_done strobe (unless flushed); EX/MEM advances
//   HALTED | absorbing until reset; halt_out high
module mem_access_unit
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter bit LLSC_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              em_valid,
  input  logic [5:0]        em_opcode,
  input  logic              em_halt,
  input  logic              em_flush,
  input  logic [ADDR_W-1:0] em_addr,
  input  logic [31:0]       em_wdata,
  input  logic              dhit,
  input  logic [31:0]       dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [31:0]       dmemstore,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              halt_out
);

  mem_state_t        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ren_q, ren_d, wen_q, wen_d;
  logic              done_q, done_d, halt_q, halt_d, flush_q, flush_d;
  logic              accept, link_set, link_clr, link_match, link_valid;
  logic [ADDR_W-1:0] cmp_addr;

  assign accept   = em_valid && !em_flush && is_mem_op(em_opcode);
  assign cmp_addr = (state_q == IDLE) ? em_addr : addr_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    done_d    = 1'b0;
    halt_d    = halt_q;
    flush_d   = flush_q;
    link_set  = 1'b0;
    link_clr  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mem_stall = 1'b1;
          op_d      = em_opcode;
          addr_d    = em_addr;
          wdata_d   = em_wdata;
          flush_d   = 1'b0;
          if (LLSC_EN && (em_opcode == SC) && !link_match) begin
            state_d  = DONE;
            done_d   = 1'b1;
            rdata_d  = SC_FAIL;
            link_clr = 1'b1;
          end else begin
            state_d = REQ;
            ren_d   = (em_opcode == LW) || (em_opcode == LL);
            wen_d   = (em_opcode == SW) || (em_opcode == SC);
          end
        end else if (em_valid && !em_flush && em_halt) begin
          state_d  = HALTED;
          halt_d   = 1'b1;
          link_clr = 1'b1;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (em_flush) flush_d = 1'b1;
        if (dhit) begin
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          // a flushed access still finishes its cache handshake and link update
          done_d  = !(flush_q || em_flush);
          if ((op_q == LW) || (op_q == LL)) rdata_d = dmemload;
          if (op_q == SC) rdata_d = SC_PASS;
          if (op_q == LL) link_set = 1'b1;
          if ((op_q == SC) || ((op_q == SW) && link_match)) link_clr = 1'b1;
        end
      end
      DONE:    state_d  = IDLE;
      HALTED:  link_clr = 1'b1;
      default: state_d  = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      halt_q  <= halt_d;
      flush_q <= flush_d;
    end
  end

  llsc_link_reg #(.ADDR_W(ADDR_W), .LLSC_EN(LLSC_EN)) u_link (
    .CLK       (CLK),
    .nRST      (nRST),
    .set_en    (link_set),
    .set_addr  (addr_q),
    .clr_en    (link_clr),
    .cmp_addr  (cmp_addr),
    .link_valid(link_valid),
    .link_match(link_match)
  );

  assign dmemREN   = ren_q;
  assign dmemWEN   = wen_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = wdata_q;
  assign mem_done  = done_q;
  assign mem_rdata = rdata_q;
  assign halt_out  = halt_q;

  logic unused_ok;
  assign unused_ok = link_valid;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a transaction-level LL/SC model.
module tb_mem_access_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        em_valid, em_halt, em_flush, dhit;
  logic [5:0]  em_opcode;
  logic [31:0] em_addr, em_wdata, dmemload;
  logic        dmemREN, dmemWEN, mem_stall, mem_done, halt_out;
  logic [31:0] dmemaddr, dmemstore, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: link register and last returned value
  logic        lv;
  logic [31:0] la, last_rd;

  mem_access_unit #(.ADDR_W(32), .LLSC_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .em_valid(em_valid), .em_opcode(em_opcode), .em_halt(em_halt),
    .em_flush(em_flush), .em_addr(em_addr), .em_wdata(em_wdata), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .halt_out(halt_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    em_valid  = 1'b0;
    em_opcode = RTYPE;
    em_halt   = 1'b0;
    em_flush  = 1'b0;
    em_addr   = '0;
    em_wdata  = '0;
    dhit      = 1'b0;
    dmemload  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ren"},   dmemREN,   0);
    chk({tag, "_wen"},   dmemWEN,   0);
    chk({tag, "_addr"},  dmemaddr,  0);
    chk({tag, "_store"}, dmemstore, 0);
    chk({tag, "_stall"}, mem_stall, 0);
    chk({tag, "_done"},  mem_done,  0);
    chk({tag, "_rdata"}, mem_rdata, 0);
    chk({tag, "_halt"},  halt_out,  0);
  endtask

  task automatic model_reset();
    lv = 1'b0; la = '0; last_rd = '0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int nwait, input logic [31:0] dload, input bit flush);
    bit is_rd, pass;
    is_rd = (op == LW) || (op == LL);
    pass  = !((op == SC) && !(lv && (la == addr)));
    em_valid = 1'b1; em_opcode = op; em_addr = addr; em_wdata = wdata;
    #1;
    chk("accept_stall", mem_stall, 1);
    @(posedge CLK); @(negedge CLK);
    em_valid = 1'b0; em_opcode = RTYPE;
    if (pass) begin
      for (int c = 0; c <= nwait; c++) begin
        em_flush = flush;
        chk("req_ren", dmemREN, is_rd);
        chk("req_wen", dmemWEN, !is_rd);
        chk("req_addr", dmemaddr, addr);
        chk("req_stall", mem_stall, 1);
        if (!is_rd) chk("req_store", dmemstore, wdata);
        if (c == nwait) begin dhit = 1'b1; dmemload = dload; end
        @(posedge CLK); @(negedge CLK);
        dhit = 1'b0; dmemload = $urandom;
      end
      em_flush = 1'b0;
      if (is_rd) last_rd = dload;
      else if (op == SC) last_rd = 32'd1;
      if (op == LL) begin lv = 1'b1; la = addr; end
      if (op == SC || (op == SW && la == addr)) lv = 1'b0;
    end else begin
      last_rd = 32'd0;
      lv      = 1'b0;
    end
    chk("done_strobe", mem_done, (pass && flush) ? 0 : 1);
    chk("done_ren", dmemREN, 0);
    chk("done_wen", dmemWEN, 0);
    chk("done_stall", mem_stall, 0);
    chk("done_rdata", mem_rdata, last_rd);
    @(posedge CLK); @(negedge CLK);
    chk("done_once", mem_done, 0);
    chk("rdata_hold", mem_rdata, last_rd);
  endtask

  initial begin
    logic [5:0]  ops [4];
    logic [31:0] addrs [3];
    ops   = '{LW, SW, LL, SC};
    addrs = '{32'h100, 32'h104, 32'h40};
    idle_inputs();
    model_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    nRST = 1'b1;
    @(negedge CLK);

    do_access(LW, 32'h40, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    do_access(SW, 32'h80, 32'h12345678, 0, 32'h0BAD0BAD, 1'b0);
    do_access(LL, 32'h100, 32'h0, 1, 32'h00000055, 1'b0);
    do_access(SC, 32'h100, 32'hA5, 0, 32'h0, 1'b0);
    do_access(SC, 32'h100, 32'hA5, 0, 32'h0, 1'b0);
    do_access(LL, 32'h100, 32'h0, 0, 32'h00000066, 1'b0);
    do_access(SW, 32'h100, 32'h77, 0, 32'h0, 1'b0);
    do_access(SC, 32'h100, 32'hA5, 0, 32'h0, 1'b0);
    do_access(LL, 32'h100, 32'h0, 0, 32'h00000088, 1'b0);
    do_access(SW, 32'h104, 32'h77, 1, 32'h0, 1'b0);
    do_access(SC, 32'h100, 32'hA5, 0, 32'h0, 1'b0);
    do_access(LW, 32'h40, 32'h0, 1, 32'hCAFEF00D, 1'b1);

    // flush in IDLE blocks acceptance
    em_valid = 1'b1; em_opcode = LW; em_addr = 32'h40; em_flush = 1'b1;
    #1;
    chk("idle_flush_stall", mem_stall, 0);
    @(posedge CLK); @(negedge CLK);
    chk("idle_flush_ren", dmemREN, 0);
    idle_inputs();

    repeat (60) begin
      do_access(ops[$urandom_range(0, 3)], addrs[$urandom_range(0, 2)], $urandom,
                int'($urandom_range(0, 3)), $urandom, $urandom_range(0, 4) == 0);
    end

    em_valid = 1'b1; em_opcode = HALT; em_halt = 1'b1;
    @(posedge CLK); @(negedge CLK);
    idle_inputs();
    chk("halt_set", halt_out, 1);
    em_valid = 1'b1; em_opcode = LW; em_addr = 32'h40;
    repeat (4) begin
      #1;
      chk("halted_stall", mem_stall, 0);
      @(posedge CLK); @(negedge CLK);
      chk("halted_ren", dmemREN, 0);
      chk("halted_sticky", halt_out, 1);
    end
    idle_inputs();

    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    @(negedge CLK);
    em_valid = 1'b1; em_opcode = LW; em_addr = 32'h40;
    @(posedge CLK); @(negedge CLK);
    idle_inputs();
    chk("pre_reset_ren", dmemREN, 1);
    #2 nRST = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_reset_ren", dmemREN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
